// File: rtl/rll27_pkg.sv
// RLL(2,7) code set shared by the encoder and decoder: codewords, data values,
// live prefixes and the width-qualified valid encoding.
package rll27_pkg;

    typedef enum logic [1:0] {V_NONE, V_W2, V_W3, V_W4} rll_valid_t;

    localparam logic [3:0] CW_10   = 4'b0100;
    localparam logic [3:0] CW_11   = 4'b1000;
    localparam logic [5:0] CW_000  = 6'b000100;
    localparam logic [5:0] CW_010  = 6'b100100;
    localparam logic [5:0] CW_011  = 6'b001000;
    localparam logic [7:0] CW_0010 = 8'b00100100;
    localparam logic [7:0] CW_0011 = 8'b00001000;

    localparam logic [1:0] D_10   = 2'b10;
    localparam logic [1:0] D_11   = 2'b11;
    localparam logic [2:0] D_000  = 3'b000;
    localparam logic [2:0] D_010  = 3'b010;
    localparam logic [2:0] D_011  = 3'b011;
    localparam logic [3:0] D_0010 = 4'b0010;
    localparam logic [3:0] D_0011 = 4'b0011;

    // Partial words that can still grow into a longer codeword.
    localparam logic [3:0] LIVE4_0 = 4'b0000;
    localparam logic [3:0] LIVE4_1 = 4'b0001;
    localparam logic [3:0] LIVE4_2 = 4'b0010;
    localparam logic [3:0] LIVE4_3 = 4'b1001;
    localparam logic [5:0] LIVE6_0 = 6'b001001;
    localparam logic [5:0] LIVE6_1 = 6'b000010;

endpackage

// File: rtl/rll27_cw_match.sv
// Combinational codeword classifier: given the candidate bits and the bit
// position, reports a full match (with width and data) or a still-live prefix.
module rll27_cw_match
    import rll27_pkg::*;
(
    input  logic [7:0] cand_i,
    input  logic [2:0] cnt_i,
    output logic       hit_o,
    output logic       live_o,
    output logic [1:0] width_o,
    output logic [3:0] data_o
);

    always_comb begin
        hit_o   = 1'b0;
        live_o  = 1'b0;
        width_o = V_NONE;
        data_o  = 4'b0000;
        case (cnt_i)
            3'd3: begin
                case (cand_i[3:0])
                    CW_10: begin
                        hit_o   = 1'b1;
                        width_o = V_W2;
                        data_o  = {2'b00, D_10};
                    end
                    CW_11: begin
                        hit_o   = 1'b1;
                        width_o = V_W2;
                        data_o  = {2'b00, D_11};
                    end
                    LIVE4_0, LIVE4_1, LIVE4_2, LIVE4_3: live_o = 1'b1;
                    default: ;
                endcase
            end
            3'd5: begin
                case (cand_i[5:0])
                    CW_000: begin
                        hit_o   = 1'b1;
                        width_o = V_W3;
                        data_o  = {1'b0, D_000};
                    end
                    CW_010: begin
                        hit_o   = 1'b1;
                        width_o = V_W3;
                        data_o  = {1'b0, D_010};
                    end
                    CW_011: begin
                        hit_o   = 1'b1;
                        width_o = V_W3;
                        data_o  = {1'b0, D_011};
                    end
                    LIVE6_0, LIVE6_1: live_o = 1'b1;
                    default: ;
                endcase
            end
            3'd7: begin
                case (cand_i)
                    CW_0010: begin
                        hit_o   = 1'b1;
                        width_o = V_W4;
                        data_o  = D_0010;
                    end
                    CW_0011: begin
                        hit_o   = 1'b1;
                        width_o = V_W4;
                        data_o  = D_0011;
                    end
                    default: ;
                endcase
            end
            // Odd lengths and lengths below 4 are never decision points.
            default: live_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rll_recv.sv
// Serial RLL(2,7) decoder: shifts in coded bits MSB first, emits 2/3/4-bit
// words with a width-qualified strobe, and flags illegal sequences.
module rll_recv
    import rll27_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       code_bit_i,
    input  logic       code_en_i,
    output logic [1:0] decode2_o,
    output logic [2:0] decode3_o,
    output logic [3:0] decode4_o,
    output logic [1:0] valid_o,
    output logic       err_o
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] dec2_q, dec2_d;
    logic [2:0] dec3_q, dec3_d;
    logic [3:0] dec4_q, dec4_d;
    logic [1:0] valid_q, valid_d;
    logic       err_q, err_d;

    logic [7:0] cand;
    logic       hit;
    logic       live;
    logic [1:0] width;
    logic [3:0] data;

    assign cand = {sr_q[6:0], code_bit_i};

    rll27_cw_match u_match (
        .cand_i  (cand),
        .cnt_i   (cnt_q),
        .hit_o   (hit),
        .live_o  (live),
        .width_o (width),
        .data_o  (data)
    );

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dec2_d  = dec2_q;
        dec3_d  = dec3_q;
        dec4_d  = dec4_q;
        valid_d = V_NONE;
        err_d   = 1'b0;
        if (code_en_i) begin
            if (hit) begin
                valid_d = width;
                sr_d    = 8'h00;
                cnt_d   = 3'd0;
                case (width)
                    V_W2:    dec2_d = data[1:0];
                    V_W3:    dec3_d = data[2:0];
                    V_W4:    dec4_d = data;
                    default: ;
                endcase
            end else if (!live) begin
                // The offending bit is dropped; framing restarts on the next bit.
                err_d = 1'b1;
                sr_d  = 8'h00;
                cnt_d = 3'd0;
            end else begin
                sr_d  = cand;
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sr_q    <= 8'h00;
            cnt_q   <= 3'd0;
            dec2_q  <= 2'b00;
            dec3_q  <= 3'b000;
            dec4_q  <= 4'b0000;
            valid_q <= V_NONE;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dec2_q  <= dec2_d;
            dec3_q  <= dec3_d;
            dec4_q  <= dec4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign decode2_o = dec2_q;
    assign decode3_o = dec3_q;
    assign decode4_o = dec4_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_rll_recv.sv
// Directed bench for rll_recv: a table-driven code-set model checked against the
// DUT every cycle, plus literal expectations on strobe position, timing and data.
module tb_rll_recv;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       code_bit_i;
    logic       code_en_i;
    logic [1:0] decode2_o;
    logic [2:0] decode3_o;
    logic [3:0] decode4_o;
    logic [1:0] valid_o;
    logic       err_o;

    always #5 clk = ~clk;

    rll_recv dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .code_bit_i (code_bit_i),
        .code_en_i  (code_en_i),
        .decode2_o  (decode2_o),
        .decode3_o  (decode3_o),
        .decode4_o  (decode4_o),
        .valid_o    (valid_o),
        .err_o      (err_o)
    );

    // Code table: codeword length/value and the data word it carries.
    int cw_len [7] = '{4, 4, 6, 6, 6, 8, 8};
    int cw_val [7] = '{4, 8, 4, 36, 8, 36, 8};
    int dw_len [7] = '{2, 2, 3, 3, 3, 4, 4};
    int dw_val [7] = '{2, 3, 0, 2, 3, 2, 3};

    typedef struct {
        int kind;  // 0 = valid strobe, 1 = error strobe
        int v;
        int d;
        int nb;
        int cy;
    } ev_t;

    ev_t log_q[$];

    int errors = 0;
    int checks = 0;
    int mlen = 0, mval = 0;
    int exp_v = 0, exp_e = 0, exp_d2 = 0, exp_d3 = 0, exp_d4 = 0;
    int nbits = 0, cyc = 0;
    int nb0 = 0, cy0 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   hit;
        bit   live;
        ev_t  ev;
        cyc++;
        if (!rst_i) begin
            mlen = 0; mval = 0;
            exp_v = 0; exp_e = 0; exp_d2 = 0; exp_d3 = 0; exp_d4 = 0;
        end else begin
            exp_v = 0;
            exp_e = 0;
            if (code_en_i) begin
                nbits++;
                mval = mval * 2 + int'(code_bit_i);
                mlen++;
                if (mlen == 4 || mlen == 6 || mlen == 8) begin
                    hit  = -1;
                    live = 1'b0;
                    for (int i = 0; i < 7; i++) begin
                        if (cw_len[i] == mlen && cw_val[i] == mval) hit = i;
                        else if (cw_len[i] > mlen && (cw_val[i] >> (cw_len[i] - mlen)) == mval)
                            live = 1'b1;
                    end
                    if (hit >= 0) begin
                        exp_v = dw_len[hit] - 1;
                        if (dw_len[hit] == 2) exp_d2 = dw_val[hit];
                        else if (dw_len[hit] == 3) exp_d3 = dw_val[hit];
                        else exp_d4 = dw_val[hit];
                        ev = '{0, exp_v, dw_val[hit], nbits, cyc};
                        log_q.push_back(ev);
                        mlen = 0; mval = 0;
                    end else if (!live) begin
                        exp_e = 1;
                        ev = '{1, 0, 0, nbits, cyc};
                        log_q.push_back(ev);
                        mlen = 0; mval = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("valid_o", int'(valid_o), exp_v);
        chk("err_o", int'(err_o), exp_e);
        chk("decode2_o", int'(decode2_o), exp_d2);
        chk("decode3_o", int'(decode3_o), exp_d3);
        chk("decode4_o", int'(decode4_o), exp_d4);
    end

    task automatic drive(input logic en, input logic b);
        @(negedge clk);
        code_en_i  = en;
        code_bit_i = b;
    endtask

    task automatic send(input int val, input int len);
        for (int i = len - 1; i >= 0; i--) drive(1'b1, 1'((val >> i) & 1));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    // Start a fresh event window; first bit sent after this lands on cycle cy0+2.
    task automatic mark();
        idle(1);
        nb0 = nbits;
        cy0 = cyc;
        log_q.delete();
    endtask

    task automatic chk_ev(input string name, input int idx, input int kind, input int v,
                          input int d, input int nb);
        if (idx >= log_q.size()) begin
            chk({name, " missing"}, 0, 1);
        end else begin
            chk({name, " kind"}, log_q[idx].kind, kind);
            chk({name, " valid"}, log_q[idx].v, v);
            chk({name, " data"}, log_q[idx].d, d);
            chk({name, " bitpos"}, log_q[idx].nb - nb0, nb);
        end
    endtask

    int exp_pos [7] = '{4, 8, 14, 20, 26, 34, 42};
    int exp_vv  [7] = '{1, 1, 2, 2, 2, 3, 3};
    int exp_dd  [7] = '{2, 3, 0, 2, 3, 2, 3};

    initial begin
        logic [31:0] data_line;
        bit          dq[$];
        bit          code_q[$];
        bit          out_q[$];
        int          pre, plen, idx, nerr;
        bit          b;

        rst_i      = 1'b0;
        code_en_i  = 1'b0;
        code_bit_i = 1'b0;

        // Reset held low while a valid codeword streams in.
        send(8, 4);
        idle(1);
        @(posedge clk); #1;
        chk("rst valid_o", int'(valid_o), 0);
        chk("rst err_o", int'(err_o), 0);
        chk("rst decode2_o", int'(decode2_o), 0);
        chk("rst decode3_o", int'(decode3_o), 0);
        chk("rst decode4_o", int'(decode4_o), 0);
        @(negedge clk);
        rst_i = 1'b1;
        mark();
        send(4, 4);
        @(posedge clk); #1;
        chk("first valid_o", int'(valid_o), 1);
        chk("first decode2_o", int'(decode2_o), 2);
        idle(2);
        chk("first count", log_q.size(), 1);
        chk_ev("first", 0, 0, 1, 2, 4);

        // Full code set back to back.
        mark();
        for (int i = 0; i < 7; i++) send(cw_val[i], cw_len[i]);
        idle(2);
        chk("set count", log_q.size(), 7);
        for (int i = 0; i < 7; i++) chk_ev("set", i, 0, exp_vv[i], exp_dd[i], exp_pos[i]);

        // Illegal 1100 then a good 1000.
        mark();
        send(12, 4);
        send(8, 4);
        idle(2);
        chk("ill count", log_q.size(), 2);
        chk_ev("ill err", 0, 1, 0, 0, 4);
        chk_ev("ill next", 1, 0, 1, 3, 8);

        // All zeros: 0000 still live, 000000 is not.
        mark();
        send(0, 8);
        idle(2);
        chk("zero count", log_q.size(), 1);
        chk_ev("zero err", 0, 1, 0, 0, 6);
        rst_i = 1'b0;
        idle(2);
        rst_i = 1'b1;

        // 00001000 unstalled, then stalled 3 cycles after bits 2 and 6.
        mark();
        send(8, 8);
        idle(2);
        chk("nostall count", log_q.size(), 1);
        if (log_q.size() > 0) chk("nostall cycle", log_q[0].cy - cy0 - 1, 8);
        mark();
        send(0, 2);
        idle(3);
        send(2, 4);
        idle(3);
        send(0, 2);
        idle(2);
        chk("stall count", log_q.size(), 1);
        chk_ev("stall", 0, 0, 3, 3, 8);
        if (log_q.size() > 0) chk("stall cycle", log_q[0].cy - cy0 - 1, 14);

        // Reset after 5 bits of 00100100, then 0100.
        mark();
        send(4, 5);
        idle(1);
        rst_i = 1'b0;
        idle(2);
        rst_i = 1'b1;
        send(4, 4);
        idle(3);
        chk("midrst count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("midrst kind", log_q[0].kind, 0);
            chk("midrst valid", log_q[0].v, 1);
            chk("midrst data", log_q[0].d, 2);
        end

        // Loopback through a bench-side encoder; trailing partial word is zero-flushed.
        data_line = 32'hC4F1_5D4C;
        for (int i = 31; i >= 0; i--) dq.push_back(data_line[i]);
        pre = 0;
        plen = 0;
        idx = 0;
        while ((idx < 32 || plen != 0) && plen < 5) begin
            b = (idx < 32) ? dq[idx] : 1'b0;
            idx++;
            pre = pre * 2 + int'(b);
            plen++;
            for (int k = 0; k < 7; k++) begin
                if (plen != 0 && dw_len[k] == plen && dw_val[k] == pre) begin
                    for (int j = cw_len[k] - 1; j >= 0; j--) code_q.push_back(bit'((cw_val[k] >> j) & 1));
                    pre = 0;
                    plen = 0;
                end
            end
        end
        mark();
        foreach (code_q[i]) drive(1'b1, code_q[i]);
        idle(2);
        nerr = 0;
        foreach (log_q[i]) begin
            if (log_q[i].kind == 1) nerr++;
            else for (int j = log_q[i].v; j >= 0; j--) out_q.push_back(bit'((log_q[i].d >> j) & 1));
        end
        chk("loop errors", nerr, 0);
        chk("loop length ok", int'(out_q.size() >= 32), 1);
        if (out_q.size() >= 32)
            for (int i = 0; i < 32; i++) chk($sformatf("loop bit %0d", i), int'(out_q[i]), int'(dq[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
